fifo_wr_ctrl: RTL

//   Write-side controller for the dual-clock instruction/data FIFO storage in cpu_top.

---
 rtl/fifo_wr_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO: producer handshake, storage write port,
// Gray pointer export and synchronised read-pointer import. Optional FIFO_WR_ALMOST_FULL_EN adds almost_full.
module fifo_wr_ctrl #(
    parameter int DEPTH       = 16,
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 12
) (
    input  logic                         wrt_clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    input  logic [$clog2(DEPTH):0]       rd_ptr_gray,
    output logic                         wr_en,
    output logic [$clog2(DEPTH)-1:0]     wr_addr,
    output logic [WIDTH-1:0]             wr_data,
    output logic [$clog2(DEPTH):0]       wr_ptr_gray,
    output logic                         full,
`ifdef FIFO_WR_ALMOST_FULL_EN
    output logic                         almost_full,
`endif
    output logic [$clog2(DEPTH):0]       level
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [PTR_WIDTH:0] FULL_LVL = (PTR_WIDTH+1)'(DEPTH);

    function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
        logic [PTR_WIDTH:0] b;
        b[PTR_WIDTH] = g[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PTR_WIDTH:0] wr_bin_q, wr_bin_d;
    logic [PTR_WIDTH:0] wr_gray_q, wr_gray_d;
    logic [PTR_WIDTH:0] sync_q [SYNC_STAGES];
    logic [PTR_WIDTH:0] rd_bin_s;
    logic [PTR_WIDTH:0] level_q, level_d;
    logic               full_q, full_d;
    logic               push;

    assign in_ready = ~reset & ~full_q;
    assign push     = in_valid & in_ready;

    assign wr_en   = push;
    assign wr_addr = wr_bin_q[PTR_WIDTH-1:0];
    assign wr_data = in_data;

    // Status is computed from the post-write pointer so the filling write sets full on its own edge.
    always_comb begin
        wr_bin_d  = wr_bin_q + {{PTR_WIDTH{1'b0}}, push};
        wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
        rd_bin_s  = gray2bin(sync_q[SYNC_STAGES-1]);
        level_d   = wr_bin_d - rd_bin_s;
        full_d    = (level_d == FULL_LVL);
    end

    always_ff @(posedge wrt_clk or posedge reset) begin
        if (reset) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            level_q   <= level_d;
            full_q    <= full_d;
        end
    end

    always_ff @(posedge wrt_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rd_ptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wr_ptr_gray = wr_gray_q;
    assign full        = full_q;
    assign level       = level_q;

`ifdef FIFO_WR_ALMOST_FULL_EN
    localparam logic [PTR_WIDTH:0] AF_LVL = (PTR_WIDTH+1)'(AF_THRESH);
    logic almost_full_q;

    // Advisory only; in_ready is gated by full alone.
    always_ff @(posedge wrt_clk or posedge reset) begin
        if (reset) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= (level_d >= AF_LVL);
        end
    end

    assign almost_full = almost_full_q;
`endif

endmodule
